// File: rtl/sine_share_arb_if.sv
// Request, sine-unit and response signals of the shared sine arbiter.
// The slave side is the arbiter; the master side is the requesters plus the sine unit.
interface sine_share_arb_if #(
   parameter int XW = 7,
   parameter int YW = 9
);
   logic          req0_valid;
   logic [XW-1:0] req0_x;
   logic          req0_ready;
   logic          req1_valid;
   logic [XW-1:0] req1_x;
   logic          req1_ready;
   logic [XW-1:0] sine_x;
   logic [YW-1:0] sine_y;
   logic          rsp0_valid;
   logic [YW-1:0] rsp0_y;
   logic          rsp1_valid;
   logic [YW-1:0] rsp1_y;
   logic          busy;

   modport slave (
      input  req0_valid, req0_x, req1_valid, req1_x, sine_y,
      output req0_ready, req1_ready, sine_x, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y, busy
   );

   modport master (
      output req0_valid, req0_x, req1_valid, req1_x, sine_y,
      input  req0_ready, req1_ready, sine_x, rsp0_valid, rsp0_y, rsp1_valid, rsp1_y, busy
   );
endinterface

// File: rtl/sine_share_arb.sv
// Round-robin share of one pipelined sine unit between two requesters; result pulses SINE_LAT edges after accept.
// Requests wait only while the other side wins a tie; responses cannot be stalled.
module sine_share_arb #(
   parameter int SINE_LAT = 3,
   parameter int XW       = 7,
   parameter int YW       = 9
) (
   input logic             clk,
   input logic             rst,
   sine_share_arb_if.slave bus
);
   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   tag_t          tag_q [SINE_LAT];
   logic          last_grant;
   logic          gnt_vld;
   logic          gnt_id;
   logic [XW-1:0] sine_x_q;
   logic          rsp0_vld_q;
   logic          rsp1_vld_q;
   logic [YW-1:0] rsp0_dat_q;
   logic [YW-1:0] rsp1_dat_q;
   logic          busy_c;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = ~last_grant;
      end else if (bus.req0_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   assign bus.req0_ready = gnt_vld && !gnt_id;
   assign bus.req1_ready = gnt_vld &&  gnt_id;

   // Tag pipeline mirrors the sine unit so the last stage lines up with sine_y.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SINE_LAT; i++) tag_q[i] <= '0;
         last_grant <= 1'b1;
         sine_x_q   <= '0;
      end else begin
         for (int i = 1; i < SINE_LAT; i++) tag_q[i] <= tag_q[i-1];
         if (gnt_vld) begin
            tag_q[0]   <= '{vld: 1'b1, id: gnt_id};
            last_grant <= gnt_id;
            sine_x_q   <= gnt_id ? bus.req1_x : bus.req0_x;
         end else begin
            tag_q[0]   <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
         rsp0_dat_q <= '0;
         rsp1_dat_q <= '0;
      end else begin
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
         if (tag_q[SINE_LAT-1].vld) begin
            if (tag_q[SINE_LAT-1].id) begin
               rsp1_vld_q <= 1'b1;
               rsp1_dat_q <= bus.sine_y;
            end else begin
               rsp0_vld_q <= 1'b1;
               rsp0_dat_q <= bus.sine_y;
            end
         end
      end
   end

   always_comb begin
      busy_c = rsp0_vld_q || rsp1_vld_q;
      for (int i = 0; i < SINE_LAT; i++) busy_c = busy_c || tag_q[i].vld;
   end

   assign bus.sine_x     = sine_x_q;
   assign bus.rsp0_valid = rsp0_vld_q;
   assign bus.rsp0_y     = rsp0_dat_q;
   assign bus.rsp1_valid = rsp1_vld_q;
   assign bus.rsp1_y     = rsp1_dat_q;
   assign bus.busy       = busy_c;
endmodule

// File: tb/tb_sine_share_arb.sv
// Bench for sine_share_arb: sine stub (y = x+1), queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sine_share_arb;
   localparam int SINE_LAT = 3;
   localparam int XW       = 7;
   localparam int YW       = 9;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sine_share_arb_if #(.XW(XW), .YW(YW)) bus ();

   sine_share_arb #(.SINE_LAT(SINE_LAT), .XW(XW), .YW(YW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Sine stub: result of the operand loaded at edge E appears after edge E+SINE_LAT-1.
   logic [YW-1:0] stub_q [SINE_LAT-1];
   always @(posedge clk) begin
      stub_q[0] <= {2'b00, bus.sine_x} + 9'd1;
      for (int k = 1; k < SINE_LAT - 1; k++) stub_q[k] <= stub_q[k-1];
   end
   assign bus.sine_y = stub_q[SINE_LAT-2];

   int vectors     = 0;
   int miscompares = 0;
   int fail_prints = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (fail_prints < 40) begin
            fail_prints++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   // Reference model: an in-flight queue of accepted operations with their due edge.
   typedef struct {
      bit id;
      int x;
      int due;
   } op_t;
   typedef struct {
      bit id;
      int y;
      int e;
   } rsp_t;

   op_t  inflight[$];
   rsp_t rlog[$];
   int   glog_id[$];
   int   glog_e[$];
   int   ecnt   = 0;
   bit   m_last = 1'b1;
   int   m_sx   = 0;
   bit   m_v0   = 1'b0;
   bit   m_v1   = 1'b0;
   int   m_y0   = 0;
   int   m_y1   = 0;
   bit   pend0  = 1'b0;
   bit   pend1  = 1'b0;
   int   px0    = 0;
   int   px1    = 0;

   function automatic int pick(logic v0, logic v1, bit last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int  g;
      op_t o;
      op_t n;
      ecnt++;
      if (rst) begin
         g    = pick(bus.req0_valid, bus.req1_valid, m_last);
         m_v0 = 1'b0;
         m_v1 = 1'b0;
         if (inflight.size() > 0 && inflight[0].due == ecnt) begin
            o = inflight.pop_front();
            if (o.id) begin m_v1 = 1'b1; m_y1 = o.x + 1; end
            else      begin m_v0 = 1'b1; m_y0 = o.x + 1; end
         end
         if (g >= 0) begin
            n.id   = (g == 1);
            n.x    = n.id ? int'(bus.req1_x) : int'(bus.req0_x);
            n.due  = ecnt + SINE_LAT;
            inflight.push_back(n);
            m_sx   = n.x;
            m_last = n.id;
         end
      end
   end

   always @(negedge clk) begin
      int   g;
      rsp_t r;
      if (!rst) begin
         inflight.delete();
         m_last = 1'b1; m_sx = 0; m_v0 = 1'b0; m_v1 = 1'b0; m_y0 = 0; m_y1 = 0;
         pend0 = 1'b0; pend1 = 1'b0;
         check("rst_sine_x", bus.sine_x, 0);
         check("rst_rsp0_valid", bus.rsp0_valid, 0);
         check("rst_rsp1_valid", bus.rsp1_valid, 0);
         check("rst_rsp0_y", bus.rsp0_y, 0);
         check("rst_rsp1_y", bus.rsp1_y, 0);
         check("rst_busy", bus.busy, 0);
      end else begin
         g = pick(bus.req0_valid, bus.req1_valid, m_last);
         check("req0_ready", bus.req0_ready, g == 0);
         check("req1_ready", bus.req1_ready, g == 1);
         check("sine_x", bus.sine_x, m_sx);
         check("rsp0_valid", bus.rsp0_valid, m_v0);
         check("rsp0_y", bus.rsp0_y, m_y0);
         check("rsp1_valid", bus.rsp1_valid, m_v1);
         check("rsp1_y", bus.rsp1_y, m_y1);
         check("busy", bus.busy, (inflight.size() > 0) || m_v0 || m_v1);
         if (pend0) check("proto_req0_hold", {bus.req0_valid, 25'd0, bus.req0_x}, {1'b1, 25'd0, px0[6:0]});
         if (pend1) check("proto_req1_hold", {bus.req1_valid, 25'd0, bus.req1_x}, {1'b1, 25'd0, px1[6:0]});
         pend0 = bus.req0_valid && !bus.req0_ready;
         pend1 = bus.req1_valid && !bus.req1_ready;
         px0   = int'(bus.req0_x);
         px1   = int'(bus.req1_x);
         if (bus.req0_valid && bus.req0_ready) begin glog_id.push_back(0); glog_e.push_back(ecnt); end
         if (bus.req1_valid && bus.req1_ready) begin glog_id.push_back(1); glog_e.push_back(ecnt); end
         if (bus.rsp0_valid) begin r.id = 1'b0; r.y = int'(bus.rsp0_y); r.e = ecnt; rlog.push_back(r); end
         if (bus.rsp1_valid) begin r.id = 1'b1; r.y = int'(bus.rsp1_y); r.e = ecnt; rlog.push_back(r); end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rlog.delete();
      glog_id.delete();
      glog_e.delete();
   endtask

   // Hold every pending request until it is accepted.
   task automatic drain_req();
      int guard = 0;
      bit a0;
      bit a1;
      while ((bus.req0_valid || bus.req1_valid) && guard < 20) begin
         @(negedge clk);
         a0 = bus.req0_ready;
         a1 = bus.req1_ready;
         tick();
         if (a0) bus.req0_valid = 1'b0;
         if (a1) bus.req1_valid = 1'b0;
         guard++;
      end
      if (bus.req0_valid || bus.req1_valid) begin
         check("req_drain_timeout", 1, 0);
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  stalls;
      int  bad;
      int  guard;
      bit  a0;
      bit  a1;
      int  w1;
      int  max1;
      int  run0;
      int  max0;
      int  acc1;

      bus.req0_valid = 1'b0; bus.req0_x = '0;
      bus.req1_valid = 1'b0; bus.req1_x = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Idle after reset
      repeat (10) tick();
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_sine_x", bus.sine_x, 0);
      check("idle_rsp0_valid", bus.rsp0_valid, 0);
      check("idle_rsp1_valid", bus.rsp1_valid, 0);
      tick();

      // Contention: grants alternate starting with requester 0
      clear_logs();
      bus.req0_valid = 1'b1; bus.req0_x = 7'd10;
      bus.req1_valid = 1'b1; bus.req1_x = 7'd20;
      repeat (8) tick();
      drain_req();
      repeat (6) tick();
      check("cont_grant_count", glog_id.size() >= 8, 1);
      if (glog_id.size() >= 8)
         for (int i = 0; i < 8; i++) check("cont_grant_order", glog_id[i], i % 2);
      check("cont_rsp_count", rlog.size() >= 4, 1);
      if (rlog.size() >= 4) begin
         check("cont_rsp0_id", rlog[0].id, 0);
         check("cont_rsp0_y", rlog[0].y, 11);
         check("cont_rsp1_id", rlog[1].id, 1);
         check("cont_rsp1_y", rlog[1].y, 21);
         check("cont_rsp2_y", rlog[2].y, 11);
         check("cont_rsp3_y", rlog[3].y, 21);
         check("cont_rsp_back_to_back", rlog[1].e - rlog[0].e, 1);
      end

      // Single request from requester 0
      clear_logs();
      bus.req0_valid = 1'b1; bus.req0_x = 7'd5;
      @(negedge clk);
      check("single_req0_ready", bus.req0_ready, 1);
      check("single_req1_ready", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      repeat (6) tick();
      check("single_rsp_count", rlog.size(), 1);
      if (rlog.size() == 1 && glog_e.size() == 1) begin
         check("single_rsp_id", rlog[0].id, 0);
         check("single_rsp_y", rlog[0].y, 6);
         check("single_latency", rlog[0].e - (glog_e[0] + 1), 3);
      end
      check("single_busy_after", bus.busy, 0);

      // Streaming x=0..127 from requester 1
      clear_logs();
      stalls = 0;
      for (int i = 0; i < 128; i++) begin
         bus.req1_x = 7'(i);
         bus.req1_valid = 1'b1;
         @(negedge clk);
         guard = 0;
         while (!bus.req1_ready && guard < 10) begin
            stalls++;
            guard++;
            @(negedge clk);
         end
         tick();
      end
      bus.req1_valid = 1'b0;
      repeat (6) tick();
      check("stream_stalls", stalls, 0);
      check("stream_rsp_count", rlog.size(), 128);
      if (rlog.size() == 128) begin
         bad = 0;
         for (int i = 0; i < 128; i++) begin
            if (rlog[i].id != 1'b1 || rlog[i].y != i + 1) bad++;
            if (i > 0 && rlog[i].e != rlog[i-1].e + 1) bad++;
         end
         check("stream_order_errors", bad, 0);
         check("stream_last_y", rlog[127].y, 128);
      end

      // Reset one cycle before the first response of two accepted operations
      clear_logs();
      bus.req0_valid = 1'b1; bus.req0_x = 7'd3;
      bus.req1_valid = 1'b1; bus.req1_x = 7'd4;
      @(negedge clk);
      a0 = bus.req0_ready; a1 = bus.req1_ready;
      tick();
      if (a0) bus.req0_valid = 1'b0;
      if (a1) bus.req1_valid = 1'b0;
      @(negedge clk);
      check("midrst_second_accept", bus.req0_ready || bus.req1_ready, 1);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (6) tick();
      check("midrst_no_rsp", rlog.size(), 0);
      check("midrst_busy", bus.busy, 0);
      bus.req0_valid = 1'b1; bus.req0_x = 7'd3;
      bus.req1_valid = 1'b1; bus.req1_x = 7'd4;
      @(negedge clk);
      check("postrst_tie_req0", bus.req0_ready, 1);
      check("postrst_tie_req1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      drain_req();
      repeat (6) tick();

      // Fairness: req0 always valid, req1 every 4th cycle
      w1 = 0; max1 = 0; run0 = 0; max0 = 0; acc1 = 0;
      bus.req0_x = 7'd0;
      for (int c = 0; c < 40; c++) begin
         if (c % 4 == 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_x = 7'(100 + c);
            w1 = 0;
         end
         bus.req0_valid = 1'b1;
         @(negedge clk);
         a0 = bus.req0_ready;
         a1 = bus.req1_ready;
         if (bus.req1_valid) begin
            if (a1) acc1++;
            else begin
               w1++;
               if (w1 > max1) max1 = w1;
            end
         end
         if (!a0) begin
            run0++;
            if (run0 > max0) max0 = run0;
         end else run0 = 0;
         tick();
         if (a1) bus.req1_valid = 1'b0;
         if (a0) bus.req0_x = bus.req0_x + 7'd1;
      end
      drain_req();
      repeat (6) tick();
      check("fair_req1_max_wait", max1 <= 1, 1);
      check("fair_req0_max_starve", max0 <= 1, 1);
      check("fair_req1_accepts", acc1, 10);
      check("fair_end_busy", bus.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
